seq_shift_reg: RTL and testbench

SEQ_SHIFT_REG -- requirements
Module: seq_shift_reg

---
 rtl/seq_shift_reg.sv | 73 +++++++
 tb/tb_seq_shift_reg.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_reg.sv
// seq_shift_reg: multi-cycle shifter (SLL/SRL/SRA/ROL) run by an IDLE/SHIFT/DONE FSM with global enable
module seq_shift_reg #(
    parameter int WIDTH = 64,
    parameter int STEP  = 1,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] load_data,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic             fill_bit,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state, w_state;
    logic [WIDTH-1:0] r_data, w_data, w_shift;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [1:0]       r_mode, w_mode;

    assign w_shift = r_mode == 2'b00 ? {r_data[WIDTH-STEP-1:0], {STEP{fill_bit}}} :
                     r_mode == 2'b01 ? {{STEP{1'b0}}, r_data[WIDTH-1:STEP]} :
                     r_mode == 2'b10 ? {{STEP{r_data[WIDTH-1]}}, r_data[WIDTH-1:STEP]} :
                                       {r_data[WIDTH-STEP-1:0], r_data[WIDTH-1:WIDTH-STEP]};

    assign out  = r_data;
    assign busy = r_state == S_SHIFT;
    assign done = r_state == S_DONE;

    // next-state and datapath; everything holds unless ena is high
    always_comb begin
        w_state = r_state;
        w_data  = r_data;
        w_cnt   = r_cnt;
        w_mode  = r_mode;
        if (ena) begin
            case (r_state)
                S_IDLE: if (start) begin
                    w_data  = load_data;
                    w_mode  = mode;
                    w_cnt   = count;
                    w_state = count != '0 ? S_SHIFT : S_DONE;
                end
                S_SHIFT: begin
                    w_data  = w_shift;
                    w_cnt   = r_cnt - 1'b1;
                    w_state = r_cnt == CNT_W'(1) ? S_DONE : S_SHIFT;
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

    // state registers with asynchronous clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
            r_mode  <= 2'b00;
        end else begin
            r_state <= w_state;
            r_data  <= w_data;
            r_cnt   <= w_cnt;
            r_mode  <= w_mode;
        end
    end
endmodule

// File: tb/tb_seq_shift_reg.sv
// tb_seq_shift_reg: random and directed checks of seq_shift_reg (WIDTH=8, STEP=1 and STEP=2) against a reference model
module tb_seq_shift_reg;
    logic       clock = 0;
    logic       reset = 1;
    logic       ena = 0;
    logic       start = 0;
    logic [7:0] load_data = 0;
    logic [1:0] mode = 0;
    logic [5:0] count = 0;
    logic       fill_bit = 0;
    logic [7:0] o1, o2;
    logic       b1, d1, b2, d2;

    int n_tot = 0;
    int n_bad = 0;

    int         m_st = 0;
    int         m_left = 0;
    logic [1:0] m_md = 0;
    logic [7:0] m_v1 = 0;
    logic [7:0] m_v2 = 0;

    logic [7:0] r1, r2;
    int         nc;

    always #5 clock = ~clock;

    seq_shift_reg #(.WIDTH(8), .STEP(1), .CNT_W(6)) u1 (
        .clock(clock), .reset(reset), .ena(ena), .start(start), .load_data(load_data),
        .mode(mode), .count(count), .fill_bit(fill_bit), .out(o1), .busy(b1), .done(d1));

    seq_shift_reg #(.WIDTH(8), .STEP(2), .CNT_W(6)) u2 (
        .clock(clock), .reset(reset), .ena(ena), .start(start), .load_data(load_data),
        .mode(mode), .count(count), .fill_bit(fill_bit), .out(o2), .busy(b2), .done(d2));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sh(input logic [7:0] v, input logic [1:0] md, input int s, input logic f);
        case (md)
            2'd0:    return (v << s) | (f ? 8'((1 << s) - 1) : 8'h00);
            2'd1:    return v >> s;
            2'd2:    return 8'($signed(v) >>> s);
            default: return (v << s) | (v >> (8 - s));
        endcase
    endfunction

    // model: 0 = idle, 1 = shifting, 2 = done
    task automatic model_step();
        if (m_st == 0) begin
            if (start) begin
                m_v1 = load_data;
                m_v2 = load_data;
                m_md = mode;
                m_left = int'(count);
                m_st = count != 0 ? 1 : 2;
            end
        end else if (m_st == 1) begin
            m_v1 = sh(m_v1, m_md, 1, fill_bit);
            m_v2 = sh(m_v2, m_md, 2, fill_bit);
            m_left--;
            if (m_left == 0) m_st = 2;
        end else m_st = 0;
    endtask

    task automatic cmp_all();
        chk("out1", o1, m_v1);
        chk("out2", o2, m_v2);
        chk("busy1", b1, m_st == 1);
        chk("done1", d1, m_st == 2);
        chk("busy2", b2, m_st == 1);
        chk("done2", d2, m_st == 2);
    endtask

    task automatic cyc();
        @(posedge clock);
        if (!reset && ena) model_step();
        #1;
        cmp_all();
    endtask

    task automatic areset();
        #2 reset = 1;
        #1;
        m_st = 0; m_left = 0; m_md = 0; m_v1 = 0; m_v2 = 0;
        chk("rst_out1", o1, 8'h00);
        chk("rst_busy1", b1, 1'b0);
        chk("rst_done1", d1, 1'b0);
        cmp_all();
        @(posedge clock);
        #1;
        cmp_all();
        reset = 0;
    endtask

    task automatic op(input logic [7:0] ld, input logic [1:0] md, input logic [5:0] cn, input logic fl,
                      input int stall_at, output logic [7:0] q1, output logic [7:0] q2, output int n);
        load_data = ld; mode = md; count = cn; fill_bit = fl; ena = 1; start = 1;
        cyc();
        start = 0;
        chk("acc_busy", b1, cn != 0);
        n = 0;
        while (!d1 && n < 200) begin
            if (n == stall_at) begin
                ena = 0; start = 1; load_data = ~ld;
                repeat (3) begin cyc(); n++; end
                ena = 1; start = 0; load_data = ld;
            end else begin
                cyc();
                n++;
            end
        end
        if (n >= 200) chk("timeout", 1'b1, 1'b0);
        q1 = o1;
        q2 = o2;
        cyc();
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("init_out1", o1, 8'h00);
        chk("init_out2", o2, 8'h00);
        cmp_all();
        reset = 0;
        ena = 1;
        cyc();

        op(8'h81, 2'd2, 6'd3, 1'b0, -1, r1, r2, nc);
        chk("sra3", r1, 8'hF0);
        chk("sra3_lat", nc, 3);
        op(8'h81, 2'd0, 6'd2, 1'b1, -1, r1, r2, nc);
        chk("sll2", r1, 8'h07);
        op(8'h81, 2'd3, 6'd1, 1'b0, -1, r1, r2, nc);
        chk("rol1", r1, 8'h03);
        op(8'h80, 2'd2, 6'd2, 1'b0, -1, r1, r2, nc);
        chk("sra_s2", r2, 8'hF8);
        op(8'h80, 2'd1, 6'd2, 1'b0, -1, r1, r2, nc);
        chk("srl_s2", r2, 8'h08);
        op(8'h5A, 2'd1, 6'd0, 1'b0, -1, r1, r2, nc);
        chk("c0_out", r1, 8'h5A);
        chk("c0_lat", nc, 0);
        op(8'h81, 2'd2, 6'd3, 1'b0, 1, r1, r2, nc);
        chk("stall_out", r1, 8'hF0);
        chk("stall_lat", nc, 6);

        load_data = 8'hFF; mode = 2'd0; count = 6'd10; fill_bit = 1'b0; start = 1;
        cyc();
        start = 0;
        repeat (3) cyc();
        areset();
        repeat (15) cyc();
        op(8'h81, 2'd2, 6'd3, 1'b0, -1, r1, r2, nc);
        chk("post_rst", r1, 8'hF0);

        op(8'hA5, 2'd1, 6'd20, 1'b0, -1, r1, r2, nc);
        chk("srl_big", r1, 8'h00);
        op(8'h85, 2'd2, 6'd63, 1'b0, -1, r1, r2, nc);
        chk("sra_big1", r1, 8'hFF);
        chk("sra_big2", r2, 8'hFF);
        op(8'h81, 2'd0, 6'd10, 1'b1, -1, r1, r2, nc);
        chk("sll_big", r1, 8'hFF);
        op(8'h81, 2'd3, 6'd10, 1'b0, -1, r1, r2, nc);
        chk("rol_big1", r1, 8'h06);
        chk("rol_big2", r2, 8'h18);

        for (int i = 0; i < 2500; i++) begin
            ena = $urandom_range(0, 7) != 0;
            start = $urandom_range(0, 2) == 0;
            load_data = 8'($urandom);
            mode = 2'($urandom);
            count = $urandom_range(0, 9) == 0 ? 6'($urandom_range(8, 63)) : 6'($urandom_range(0, 6));
            fill_bit = 1'($urandom);
            cyc();
            if ($urandom_range(0, 299) == 0) areset();
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
